// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_if
// Brief    : Command/response/ALU bundle for the round-robin ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rr_arbiter_if #(
    parameter int N = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_data;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_data;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_opcode;
    logic [N-1:0] alu_result;
    logic         busy;

    // Environment side: requesters plus the ALU instance.
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready, alu_result,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  alu_a, alu_b, alu_opcode, busy
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready, alu_result,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output alu_a, alu_b, alu_opcode, busy
    );
endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Brief    : Round-robin sharing of one combinational ALU between two clients.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int N = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         r_ptr;
    logic         r_owner;
    logic [N-1:0] r_alu_a;
    logic [N-1:0] r_alu_b;
    logic [2:0]   r_alu_op;
    logic [N-1:0] r_rsp0_data;
    logic [N-1:0] r_rsp1_data;
    logic         r_rsp0_valid;
    logic         r_rsp1_valid;
    logic         w_req0_ready;
    logic         w_req1_ready;
    logic         w_rsp_hs;

    always_comb begin
        w_state_next = r_state;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Pointer side wins only when both are requesting.
                w_req0_ready = bus.req0_valid && (!r_ptr || !bus.req1_valid);
                w_req1_ready = bus.req1_valid && ( r_ptr || !bus.req0_valid);
                if (w_req0_ready || w_req1_ready) begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_hs = r_owner ? (r_rsp1_valid && bus.rsp1_ready)
                                   : (r_rsp0_valid && bus.rsp0_ready);
                if (w_rsp_hs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= 1'b0;
            r_owner      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_req1_ready) begin
                r_alu_a  <= bus.req1_a;
                r_alu_b  <= bus.req1_b;
                r_alu_op <= bus.req1_op;
                r_owner  <= 1'b1;
            end else if (w_req0_ready) begin
                r_alu_a  <= bus.req0_a;
                r_alu_b  <= bus.req0_b;
                r_alu_op <= bus.req0_op;
                r_owner  <= 1'b0;
            end
            // Only the owner's response register is touched.
            if (r_state == S_EXEC) begin
                if (r_owner) begin
                    r_rsp1_data  <= bus.alu_result;
                    r_rsp1_valid <= 1'b1;
                end else begin
                    r_rsp0_data  <= bus.alu_result;
                    r_rsp0_valid <= 1'b1;
                end
            end
            if (w_rsp_hs) begin
                r_rsp0_valid <= 1'b0;
                r_rsp1_valid <= 1'b0;
                r_ptr        <= ~r_owner;
            end
        end
    end

    assign bus.req0_ready = w_req0_ready;
    assign bus.req1_ready = w_req1_ready;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_data  = r_rsp0_data;
    assign bus.rsp1_data  = r_rsp1_data;
    assign bus.busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_arbiter
// Brief    : Directed, table-driven self-checking bench for alu_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] last0;
    logic [7:0] last1;

    alu_rr_arbiter_if #(.N(8)) bus ();

    alu_rr_arbiter #(.N(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a ^ b;
            default: return 8'hFF;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_opcode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       req;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    endtask

    // Called just after a falling edge; returns just after a falling edge.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); @(posedge clk); @(negedge clk); #1;
        chk({name, "_outs"}, {bus.alu_a, bus.alu_b, 5'(bus.alu_opcode), bus.rsp0_data},
            32'h0);
        chk({name, "_flags"}, {bus.rsp1_data, bus.rsp0_valid, bus.rsp1_valid, bus.busy,
            bus.req0_ready, bus.req1_ready}, 32'h0);
        rst_n = 1'b1;
        last0 = 8'h00;
        last1 = 8'h00;
        @(negedge clk);
    endtask

    task automatic run_op(input logic r, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] exp, input string name);
        if (r) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        chk({name, "_ready"}, {bus.req1_ready, bus.req0_ready}, r ? 2'b10 : 2'b01);
        @(posedge clk); @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk({name, "_exec"}, {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.alu_opcode,
            bus.alu_a, bus.alu_b}, {1'b1, 2'b00, op, a, b});
        @(posedge clk); @(negedge clk); #1;
        chk({name, "_rspv"}, {bus.rsp1_valid, bus.rsp0_valid}, r ? 2'b10 : 2'b01);
        chk({name, "_data"}, {bus.rsp1_data, bus.rsp0_data},
            r ? {exp, last0} : {last1, exp});
        if (r) last1 = exp; else last0 = exp;
        @(posedge clk); @(negedge clk); #1;
        chk({name, "_done"}, {bus.rsp1_valid, bus.rsp0_valid, bus.busy}, 3'b000);
    endtask

    initial begin
        int n;
        int last_cyc;
        checks   = 0;
        failures = 0;
        last0    = 8'h00;
        last1    = 8'h00;
        rst_n    = 1'b0;
        idle_inputs();

        vecs[0] = '{1'b0, 8'h05, 8'h03, 3'b000, 8'h08, "add0"};
        vecs[1] = '{1'b1, 8'h0A, 8'h03, 3'b001, 8'h07, "sub1"};
        vecs[2] = '{1'b0, 8'hF0, 8'h3C, 3'b010, 8'h30, "and0"};
        vecs[3] = '{1'b1, 8'hAA, 8'hFF, 3'b011, 8'h55, "xor1"};
        vecs[4] = '{1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, "wrap0"};
        vecs[5] = '{1'b1, 8'h12, 8'h34, 3'b111, 8'hFF, "undef1"};
        vecs[6] = '{1'b0, 8'h03, 8'h05, 3'b001, 8'hFE, "subneg0"};

        @(negedge clk);
        do_reset("reset");
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].name);
        end

        // Simultaneous requests and strict alternation from a fresh pointer.
        do_reset("reset2");
        bus.req0_valid = 1'b1; bus.req0_a = 8'h0A; bus.req0_b = 8'h03; bus.req0_op = 3'b001;
        bus.req1_valid = 1'b1; bus.req1_a = 8'hF0; bus.req1_b = 8'h3C; bus.req1_op = 3'b010;
        n = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            #1;
            if (bus.rsp0_valid) chk("fair_rsp0", bus.rsp0_data, 8'h07);
            if (bus.rsp1_valid) chk("fair_rsp1", bus.rsp1_data, 8'h30);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("fair_grant", {bus.req1_ready, bus.req0_ready}, (n % 2) ? 2'b10 : 2'b01);
                if (n > 0) chk("fair_spacing", cyc - last_cyc, 3);
                last_cyc = cyc;
                n++;
            end
            @(negedge clk);
        end
        chk("fair_count", n, 6);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("ptr_after_fair", {bus.req1_ready, bus.req0_ready}, 2'b01);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        last0 = 8'h07;
        last1 = 8'h30;
        @(negedge clk);

        // Response backpressure while the other requester waits.
        bus.rsp1_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'hAA; bus.req1_b = 8'hFF; bus.req1_op = 3'b011;
        #1;
        chk("bp_accept1", bus.req1_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02; bus.req0_op = 3'b000;
        #1;
        chk("bp_exec_block", bus.req0_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("bp_hold", {bus.rsp1_valid, bus.rsp1_data, bus.req0_ready, bus.rsp0_valid},
                {1'b1, 8'h55, 1'b0, 1'b0});
        end
        @(negedge clk);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_resp_block", bus.req0_ready, 1'b0);
        @(negedge clk); #1;
        chk("bp_released", {bus.rsp1_valid, bus.req0_ready}, 2'b01);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_rsp0", {bus.rsp0_valid, bus.rsp0_data, bus.rsp1_data}, {1'b1, 8'h03, 8'h55});
        last0 = 8'h03;
        last1 = 8'h55;
        @(negedge clk);

        // Reset during EXEC discards the command.
        bus.req0_valid = 1'b1; bus.req0_a = 8'h11; bus.req0_b = 8'h22; bus.req0_op = 3'b000;
        #1;
        chk("mid_accept", bus.req0_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("mid_outs", {bus.alu_a, bus.alu_b, 5'(bus.alu_opcode), bus.rsp0_data}, 32'h0);
        chk("mid_flags", {bus.rsp1_data, bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 32'h0);
        rst_n = 1'b1;
        last0 = 8'h00;
        last1 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("mid_no_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.busy}, 3'b000);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("mid_ptr_reset", {bus.req1_ready, bus.req0_ready}, 2'b01);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        run_op(1'b0, 8'h11, 8'h22, 3'b000, 8'h33, "post_reset0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
